// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider and its neighbouring arithmetic blocks.
package seq_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/seq_divider_trial_sub.sv
// Combinational (WIDTH+1)-bit trial subtraction rs - {0,d} built from full-adder cells.
module trial_sub
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rs,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] carry;

  // Subtraction as rs + ~d + 1 rippled through the adder cells.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign {carry[i+1], diff[i]} = full_add(rs[i], ~d[i], carry[i]);
  end

  // Top bit sees the zero-extended divisor; its sum bit is the sign of the trial result.
  assign borrow = rs[WIDTH] ^ 1'b1 ^ carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  // Partial remainder; its extra top bit is provably always zero, so it is not stored.
  logic [WIDTH-1:0] r_reg;

  logic [WIDTH:0]   rs;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_iter;

  assign rs        = {r_reg, q_reg[WIDTH-1]};
  assign r_nxt     = borrow ? rs[WIDTH-1:0] : diff;
  assign q_nxt     = {q_reg[WIDTH-2:0], ~borrow};
  assign last_iter = (cnt == CW'(1));

  trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .rs    (rs),
    .d     (d_reg),
    .diff  (diff),
    .borrow(borrow)
  );

  // Next-state logic; a start in DONE is accepted exactly as in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = (divisor == '0) ? S_DONE : S_RUN;
        else       state_nxt = S_IDLE;
      end
      S_RUN:   if (last_iter) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_nxt == S_RUN);
      done <= (state_nxt == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (divisor != '0) begin
              q_reg       <= dividend;
              d_reg       <= divisor;
              r_reg       <= '0;
              cnt         <= CW'(WIDTH);
              div_by_zero <= 1'b0;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_reg <= r_nxt;
          q_reg <= q_nxt;
          cnt   <= cnt - CW'(1);
          if (last_iter) begin
            quotient  <= q_nxt;
            remainder <= r_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: WIDTH=4 directed/exhaustive runs plus one WIDTH=8 check.
module tb_seq_divider;

  localparam int W = 4;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         t;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dvd = '0;
  logic [3:0] dvs = '0;
  logic       busy, done, dbz;
  logic [3:0] quo, rem;

  logic       start8 = 1'b0;
  logic [7:0] dvd8 = '0;
  logic [7:0] dvs8 = '0;
  logic       busy8, done8, dbz8;
  logic [7:0] quo8, rem8;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   left  = 0;
  exp_t sb[$];
  exp_t cur;
  exp_t item;

  seq_divider #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dvd), .divisor(dvs),
    .busy(busy), .done(done), .quotient(quo), .remainder(rem), .div_by_zero(dbz)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8), .div_by_zero(dbz8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  // Scoreboard: model acceptance and busy, push on accept, pop and compare on done.
  always @(negedge clk) begin
    if (rst) begin
      left = 0;
      sb.delete();
    end else begin
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", int'(done), 0);
        else begin
          cur = sb.pop_front();
          chk("quotient", int'(quo), int'(cur.q));
          chk("remainder", int'(rem), int'(cur.r));
          chk("div_by_zero", int'(dbz), int'(cur.dbz));
          chk("latency", cyc - cur.t, cur.lat);
        end
      end else if (sb.size() > 0 && (cyc - sb[0].t) > sb[0].lat) begin
        chk("done_timeout", int'(done), 1);
        void'(sb.pop_front());
      end
      chk("busy", int'(busy), int'(left > 0));
      if (left > 0) left--;
      else if (start) begin
        if (dvs == 4'd0) begin
          item.q = 4'hF; item.r = dvd; item.dbz = 1'b1; item.lat = 1;
        end else begin
          item.q = 4'(dvd / dvs); item.r = 4'(dvd % dvs); item.dbz = 1'b0; item.lat = W + 1;
        end
        item.t = cyc;
        sb.push_back(item);
        left = (dvs == 4'd0) ? 0 : W;
      end
    end
  end

  task automatic run_op(input logic [3:0] a, input logic [3:0] b);
    int tries = 0;
    do begin
      @(posedge clk); #1;
      tries++;
    end while (left != 0 && tries < 40);
    if (left != 0) chk("ready_timeout", left, 0);
    start = 1'b1; dvd = a; dvs = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int tries = 0;
    do begin
      @(posedge clk); #1;
      tries++;
    end while ((left != 0 || sb.size() != 0) && tries < 100);
    if (left != 0 || sb.size() != 0) chk("idle_timeout", sb.size(), 0);
  endtask

  initial begin
    int lat8;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quo), 0);
    chk("rst_remainder", int'(rem), 0);
    chk("rst_dbz", int'(dbz), 0);
    chk("rst_quotient8", int'(quo8), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic op, then outputs must hold.
    run_op(4'd13, 4'd4);
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("hold_quotient", int'(quo), 3);
    chk("hold_remainder", int'(rem), 1);

    run_op(4'd15, 4'd1);
    run_op(4'd3, 4'd7);
    run_op(4'd15, 4'd15);
    run_op(4'd0, 4'd5);
    run_op(4'd9, 4'd0);
    run_op(4'd6, 4'd3);
    wait_idle();

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(4'(a), 4'(b));
    wait_idle();

    // Start held high; operands change while an op is in flight.
    @(posedge clk); #1;
    start = 1'b1; dvd = 4'd10; dvs = 4'd3;
    repeat (7) @(posedge clk);
    #1;
    dvd = 4'd1; dvs = 4'd1;
    repeat (8) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #1;
    start = 1'b1; dvd = 4'd14; dvs = 4'd3;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_quotient", int'(quo), 0);
    chk("arst_remainder", int'(rem), 0);
    chk("arst_dbz", int'(dbz), 0);
    #12 rst = 1'b0;
    run_op(4'd14, 4'd3);
    wait_idle();

    // WIDTH=8 instance.
    @(posedge clk); #1;
    start8 = 1'b1; dvd8 = 8'd200; dvs8 = 8'd7;
    @(posedge clk); #1 start8 = 1'b0;
    lat8 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk("w8_busy", int'(busy8), 1);
      if (done8) begin
        lat8 = k;
        break;
      end
    end
    chk("w8_latency", lat8, 9);
    chk("w8_quotient", int'(quo8), 28);
    chk("w8_remainder", int'(rem8), 4);
    chk("w8_dbz", int'(dbz8), 0);

    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
